// File: rtl/tag_pkg.sv
// Shared tag-receiver definitions: PIE front-end FSM encoding and default timing limits.
package tag_pkg;

  typedef enum logic [1:0] {
    S_HIGH = 2'd0,
    S_LOW  = 2'd1,
    S_LOST = 2'd2
  } pie_state_e;

  localparam int DELIM_MIN   = 18;
  localparam int DELIM_MAX   = 36;
  localparam int CW_LOST_CYC = 400;

  function automatic logic in_window(input int unsigned v, input int unsigned lo,
                                     input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pie_glitch_filter.sv
// Two-flop synchroniser plus FILT_LEN-sample agreement filter on the PIE envelope.
// o_*_nxt flag that o_pie toggles at the coming edge so a downstream FSM can move in step.
module pie_glitch_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic i_clr,
  input  logic i_raw,
  output logic o_pie,
  output logic o_fall,
  output logic o_rise,
  output logic o_fall_nxt,
  output logic o_rise_nxt
);
  localparam int FCNT_W = 3;

  logic              r_s1, r_s2, r_pie, r_fall, r_rise;
  logic [FCNT_W-1:0] r_fcnt;
  logic              w_diff, w_tog;

  assign w_diff     = (r_s2 != r_pie);
  assign w_tog      = w_diff && (r_fcnt == FCNT_W'(FILT_LEN - 1));
  assign o_fall_nxt = w_tog && r_pie;
  assign o_rise_nxt = w_tog && !r_pie;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_pie  <= 1'b1;
      r_fcnt <= '0;
      r_fall <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_fall <= o_fall_nxt;
      r_rise <= o_rise_nxt;
      if (w_tog) begin
        r_pie  <= r_s2;
        r_fcnt <= '0;
      end else if (w_diff) begin
        r_fcnt <= r_fcnt + 1'b1;
      end else begin
        r_fcnt <= '0;
      end
    end
  end

  assign o_pie  = r_pie;
  assign o_fall = r_fall;
  assign o_rise = r_rise;

endmodule

// File: rtl/pie_frontend.sv
// PIE envelope conditioning: glitch filter, low-pulse width measurement,
// delimiter qualification and carrier-loss detection.
module pie_frontend
  import tag_pkg::*;
#(
  parameter int FILT_LEN    = 3,
  parameter int CNT_W       = 9,
  parameter int DELIM_MIN   = tag_pkg::DELIM_MIN,
  parameter int DELIM_MAX   = tag_pkg::DELIM_MAX,
  parameter int CW_LOST_CYC = tag_pkg::CW_LOST_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_pie_raw,
  output logic             o_pie,
  output logic             o_fall,
  output logic             o_rise,
  output logic [CNT_W-1:0] o_low_width,
  output logic             o_delim,
  output logic             o_cw_lost
);
  logic w_clr, w_fall_nxt, w_rise_nxt;

  assign w_clr = rst || !i_en;

  pie_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk        (clk),
    .i_clr      (w_clr),
    .i_raw      (i_pie_raw),
    .o_pie      (o_pie),
    .o_fall     (o_fall),
    .o_rise     (o_rise),
    .o_fall_nxt (w_fall_nxt),
    .o_rise_nxt (w_rise_nxt)
  );

  pie_state_e       r_state, w_state;
  logic [CNT_W-1:0] r_lcnt, w_lcnt, w_lcnt_inc;
  logic [CNT_W-1:0] r_low_width, w_low_width;
  logic             r_delim, w_delim, r_cw_lost, w_cw_lost;

  assign w_lcnt_inc = (r_lcnt == {CNT_W{1'b1}}) ? r_lcnt : r_lcnt + 1'b1;

  // FSM steps on the filter's pre-edge strobes so width/delim land with o_rise.
  always_comb begin
    w_state     = r_state;
    w_lcnt      = r_lcnt;
    w_low_width = r_low_width;
    w_delim     = 1'b0;
    w_cw_lost   = r_cw_lost;
    case (r_state)
      S_HIGH: begin
        if (w_fall_nxt) begin
          w_lcnt  = CNT_W'(1);
          w_state = S_LOW;
        end
      end
      S_LOW: begin
        if (w_rise_nxt) begin
          w_low_width = r_lcnt;
          w_delim     = in_window(32'(r_lcnt), DELIM_MIN, DELIM_MAX);
          w_state     = S_HIGH;
        end else begin
          w_lcnt = w_lcnt_inc;
          if (w_lcnt_inc == CNT_W'(CW_LOST_CYC)) begin
            w_cw_lost = 1'b1;
            w_state   = S_LOST;
          end
        end
      end
      S_LOST: begin
        if (w_rise_nxt) begin
          w_cw_lost   = 1'b0;
          w_low_width = r_lcnt;
          w_state     = S_HIGH;
        end else begin
          w_lcnt = w_lcnt_inc;
        end
      end
      default: w_state = S_HIGH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state     <= S_HIGH;
      r_lcnt      <= '0;
      r_low_width <= '0;
      r_delim     <= 1'b0;
      r_cw_lost   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_lcnt      <= w_lcnt;
      r_low_width <= w_low_width;
      r_delim     <= w_delim;
      r_cw_lost   <= w_cw_lost;
    end
  end

  assign o_low_width = r_low_width;
  assign o_delim     = r_delim;
  assign o_cw_lost   = r_cw_lost;

endmodule

// File: tb/tb_pie_frontend.sv
// Directed bench for pie_frontend: reset, glitch rejection, delimiter limits,
// data-0 symbols, carrier loss and enable abort.
module tb_pie_frontend;
  import tag_pkg::*;

  localparam int CNT_W = 9;
  localparam int LAT   = 5;  // 2 sync stages + FILT_LEN(3)

  logic             clk = 1'b0;
  logic             rst, i_en, i_pie_raw;
  logic             o_pie, o_fall, o_rise, o_delim, o_cw_lost;
  logic [CNT_W-1:0] o_low_width;

  pie_frontend dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_pie_raw  (i_pie_raw),
    .o_pie      (o_pie),
    .o_fall     (o_fall),
    .o_rise     (o_rise),
    .o_low_width(o_low_width),
    .o_delim    (o_delim),
    .o_cw_lost  (o_cw_lost)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int nfall, nrise, last_lw, last_delim, rise_lat, cw_at, lowcnt, cw_drop, cw_at_rise, stray;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sampling only: tallies what the outputs did during one pulse.
  task automatic observe(input int k);
    if (o_fall) nfall++;
    if (o_rise) begin
      nrise++;
      last_lw    = int'(o_low_width);
      last_delim = int'(o_delim);
      cw_at_rise = int'(o_cw_lost);
      if (rise_lat < 0 && k > 0) rise_lat = k;
    end
    if (o_delim && !o_rise) stray++;
    if (!o_pie) lowcnt++;
    if (o_cw_lost && cw_at < 0) cw_at = lowcnt;
    if (cw_at >= 0 && !o_cw_lost && !o_pie) cw_drop++;
  endtask

  task automatic run_pulse(input int nlow, input int nhigh);
    nfall = 0; nrise = 0; rise_lat = -1; cw_at = -1; lowcnt = 0;
    cw_drop = 0; cw_at_rise = -1; stray = 0; last_lw = -1; last_delim = -1;
    i_pie_raw = 1'b0;
    for (int i = 0; i < nlow; i++) begin tick(); observe(-1); end
    i_pie_raw = 1'b1;
    for (int i = 0; i < nhigh; i++) begin tick(); observe(i + 1); end
  endtask

  task automatic test_reset();
    int first_low;
    rst = 1'b1; i_en = 1'b1; i_pie_raw = 1'b0;
    repeat (3) tick();
    nvec++;
    if ({o_pie, o_fall, o_rise, o_delim, o_cw_lost} !== 5'b10000) begin
      nerr++; $display("FAIL reset_flags: got %b want 10000", {o_pie, o_fall, o_rise, o_delim, o_cw_lost});
    end
    nvec++;
    if (o_low_width !== '0) begin
      nerr++; $display("FAIL reset_low_width: got %0d want 0", o_low_width);
    end
    rst = 1'b0;
    first_low = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (!o_pie && first_low < 0) first_low = i;
    end
    nvec++;
    if (first_low != LAT) begin
      nerr++; $display("FAIL reset_release_latency: got %0d want %0d", first_low, LAT);
    end
    i_pie_raw = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_glitch();
    int lw0;
    lw0 = int'(o_low_width);
    run_pulse(1, 8);
    nvec++;
    if (nfall != 0 || lowcnt != 0) begin
      nerr++; $display("FAIL glitch_1cyc: falls %0d lowcycles %0d want 0 0", nfall, lowcnt);
    end
    run_pulse(2, 8);
    nvec++;
    if (nfall != 0 || lowcnt != 0) begin
      nerr++; $display("FAIL glitch_2cyc: falls %0d lowcycles %0d want 0 0", nfall, lowcnt);
    end
    nvec++;
    if (int'(o_low_width) != lw0) begin
      nerr++; $display("FAIL glitch_width_kept: got %0d want %0d", o_low_width, lw0);
    end
  endtask

  task automatic test_delim_bounds();
    int widths [4] = '{17, 18, 36, 37};
    int exp_dl [4] = '{0, 1, 1, 0};
    for (int t = 0; t < 4; t++) begin
      run_pulse(widths[t], 12);
      nvec++;
      if (nrise != 1 || nfall != 1) begin
        nerr++; $display("FAIL bound%0d_edges: fall %0d rise %0d want 1 1", widths[t], nfall, nrise);
      end
      nvec++;
      if (last_lw != widths[t]) begin
        nerr++; $display("FAIL bound%0d_width: got %0d want %0d", widths[t], last_lw, widths[t]);
      end
      nvec++;
      if (last_delim != exp_dl[t] || stray != 0) begin
        nerr++; $display("FAIL bound%0d_delim: got %0d stray %0d want %0d", widths[t], last_delim, stray, exp_dl[t]);
      end
      nvec++;
      if (rise_lat != LAT) begin
        nerr++; $display("FAIL bound%0d_rise_latency: got %0d want %0d", widths[t], rise_lat, LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    int tf = 0, tr = 0;
    for (int s = 0; s < 4; s++) begin
      run_pulse(24, 48);
      tf += nfall; tr += nrise;
      nvec++;
      if (last_lw != 24 || last_delim != 1) begin
        nerr++; $display("FAIL data0_sym%0d: width %0d delim %0d want 24 1", s, last_lw, last_delim);
      end
    end
    nvec++;
    if (tf != 4 || tr != 4) begin
      nerr++; $display("FAIL data0_edges: fall %0d rise %0d want 4 4", tf, tr);
    end
  endtask

  task automatic test_cw_lost();
    run_pulse(500, 12);
    nvec++;
    if (cw_at != 400) begin
      nerr++; $display("FAIL cw_lost_onset: got low count %0d want 400", cw_at);
    end
    nvec++;
    if (cw_drop != 0) begin
      nerr++; $display("FAIL cw_lost_held: dropped %0d cycles want 0", cw_drop);
    end
    nvec++;
    if (nrise != 1 || cw_at_rise != 0 || o_cw_lost !== 1'b0) begin
      nerr++; $display("FAIL cw_lost_clear: rise %0d cw_at_rise %0d cw %b want 1 0 0", nrise, cw_at_rise, o_cw_lost);
    end
    nvec++;
    if (last_lw != 500 || last_delim != 0) begin
      nerr++; $display("FAIL cw_lost_width: width %0d delim %0d want 500 0", last_lw, last_delim);
    end
  endtask

  task automatic test_abort();
    int lc = 0, nr = 0, nd = 0;
    i_pie_raw = 1'b0;
    for (int i = 0; i < 60 && lc < 20; i++) begin
      tick();
      if (!o_pie) lc++;
    end
    nvec++;
    if (lc != 20) begin
      nerr++; $display("FAIL abort_reach_low20: got %0d want 20", lc);
    end
    i_en = 1'b0;
    tick();
    nvec++;
    if (o_low_width !== '0 || o_pie !== 1'b1) begin
      nerr++; $display("FAIL abort_disable_state: width %0d pie %b want 0 1", o_low_width, o_pie);
    end
    i_pie_raw = 1'b1;
    tick();
    i_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (o_rise) nr++;
      if (o_delim) nd++;
    end
    nvec++;
    if (nr != 0 || nd != 0) begin
      nerr++; $display("FAIL abort_no_pulse: rise %0d delim %0d want 0 0", nr, nd);
    end
    nvec++;
    if (dut.r_state !== S_HIGH || o_low_width !== '0 || o_cw_lost !== 1'b0) begin
      nerr++; $display("FAIL abort_idle: state %0d width %0d cw %b want 0 0 0", dut.r_state, o_low_width, o_cw_lost);
    end
    run_pulse(24, 12);
    nvec++;
    if (last_lw != 24 || last_delim != 1) begin
      nerr++; $display("FAIL abort_recover: width %0d delim %0d want 24 1", last_lw, last_delim);
    end
  endtask

  initial begin
    rst = 1'b1; i_en = 1'b1; i_pie_raw = 1'b1;
    test_reset();
    test_glitch();
    test_delim_bounds();
    test_back_to_back();
    test_cw_lost();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
